// File: rtl/demux_pkg.sv
// Shared constants and types for the four-channel stream demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned CH_IDX_W = 2;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_e;

endpackage

// File: rtl/demux_ch_slot.sv
// One-entry output slot for a single demux channel: load, drain and registered data/valid.
module demux_ch_slot
  import demux_pkg::*;
#(
  parameter int unsigned DataW = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DataW-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic             can_accept_o
);

  slot_state_e      state_q, state_d;
  logic [DataW-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      // A load in the same cycle as a drain replaces the entry without a bubble.
      state_d = SLOT_FULL;
      data_d  = data_i;
    end else if ((state_q == SLOT_FULL) && ready_i) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o      = (state_q == SLOT_FULL);
  assign data_o       = data_q;
  assign can_accept_o = (state_q == SLOT_EMPTY) || ready_i;

endmodule

// File: rtl/stream_demux4.sv
// Four-way stream demultiplexer with one-entry registered slot per channel.
// Optional DEMUX_RR_EN: ignore sel and distribute beats round-robin.
module stream_demux4
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  input  logic [1:0]        sel,
  input  logic              d_valid,
  output logic              d_ready,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] y3,
  output logic [3:0]        y_valid,
  input  logic [3:0]        y_ready,
  output logic [15:0]       accept_cnt
);

  logic [CH_IDX_W-1:0] target;
  logic [NUM_CH-1:0]   can_accept;
  logic [NUM_CH-1:0]   load;
  logic [NUM_CH-1:0]   valid;
  logic [DATA_W-1:0]   ydata [NUM_CH];
  logic                xfer;
  logic [15:0]         cnt_q;

`ifdef DEMUX_RR_EN
  logic [CH_IDX_W-1:0] ptr_q;
  logic                unused_sel;

  // Pointer holds on a stalled target; channels are never skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  assign target     = ptr_q;
  assign unused_sel = ^sel;
`else
  assign target = sel;
`endif

  assign d_ready = can_accept[target];
  assign xfer    = d_valid && d_ready;

  always_comb begin
    load         = '0;
    load[target] = xfer;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_ch_slot #(
      .DataW (DATA_W)
    ) u_slot (
      .clk_i        (clk),
      .rst_i        (rst),
      .load_i       (load[i]),
      .data_i       (d),
      .ready_i      (y_ready[i]),
      .valid_o      (valid[i]),
      .data_o       (ydata[i]),
      .can_accept_o (can_accept[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign y0         = ydata[0];
  assign y1         = ydata[1];
  assign y2         = ydata[2];
  assign y3         = ydata[3];
  assign y_valid    = valid;
  assign accept_cnt = cnt_q;

endmodule

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 Parameter: DATA_W, default 8, width of the data path.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: d  input  DATA_W  input data beat.
REQ-005 Port: sel  input  2  destination channel for d (0..3).
REQ-006 Port: d_valid  input  1  d/sel hold a beat.
REQ-007 Port: d_ready  output  1  block accepts the beat this cycle.
REQ-008 Port: y0, y1, y2, y3  output  DATA_W each  per-channel registered output data.
REQ-009 Port: y_valid  output  4  bit i set = yi holds an undelivered beat.
REQ-010 Port: y_ready  input  4  bit i set = consumer i takes yi this cycle.
REQ-011 Port: accept_cnt  output  16  count of accepted input beats.

Function
REQ-012 Each channel SHALL hold a one-entry slot in state EMPTY or FULL; y_valid[i] = (slot i FULL).
REQ-013 Transfer on input: d_valid && d_ready at a rising edge; transfer on output i: y_valid[i] && y_ready[i].
REQ-014 d_ready SHALL be combinational: (target slot EMPTY) or (target slot FULL and its y_ready bit set); target = sel (or RR pointer, REQ-024).
REQ-015 Latency: a beat accepted at edge N SHALL appear on y[target] with y_valid set from edge N through the cycle of its output transfer; one cycle minimum.
REQ-016 Slot transitions: EMPTY->FULL on input transfer; FULL->EMPTY on output transfer with no input transfer; FULL->FULL with new data when both occur in the same cycle (no bubble).
REQ-017 yi and y_valid[i] SHALL remain stable while y_valid[i]=1 and y_ready[i]=0.
REQ-018 A full, stalled channel SHALL NOT block acceptance of beats for other channels.
REQ-019 y_ready bits for EMPTY channels SHALL be ignored; d SHALL be ignored when d_valid=0.
REQ-020 accept_cnt SHALL increment by 1 per input transfer and wrap 0xFFFF->0x0000.
REQ-021 Data SHALL never be duplicated or dropped outside reset.

Reset
REQ-022 On rst=1 at a rising edge: all slots EMPTY, y_valid=4'b0000, y0..y3=0, accept_cnt=0, RR pointer=0; d_ready SHALL evaluate as 1 from the next cycle.
REQ-023 rst asserted mid-operation SHALL discard all buffered beats; a simultaneous input transfer SHALL be ignored and not counted.

Configuration
REQ-024 Macro DEMUX_RR_EN: when defined, sel SHALL be ignored and the target is a 2-bit round-robin pointer advancing by 1 (3->0 wrap) only on an input transfer; if the pointed slot cannot accept, d_ready=0 and the pointer holds (no skipping).
REQ-025 Without DEMUX_RR_EN: target = sel; no pointer register is instantiated.

Structure
REQ-026 Package demux_pkg SHALL hold NUM_CH=4, CH_IDX_W=2 and the slot state enum {SLOT_EMPTY, SLOT_FULL}.
REQ-027 Sub-module demux_ch_slot SHALL implement one channel slot (load, drain, data, valid) and be instantiated four times.

Verification
REQ-028 After reset, d=8'hA5, sel=2, d_valid=1 for one cycle, y_ready=0 -> next cycle y_valid=4'b0100, y2=8'hA5, accept_cnt=1; held stable while stalled.
REQ-029 Channel 1 FULL, y_ready[1]=0, send sel=1 -> d_ready=0, no count change; then send sel=3, d=8'h3C -> accepted, y3=8'h3C.
REQ-030 Channel 0 FULL with 8'h11, y_ready[0]=1 and input d=8'h22 sel=0 same cycle -> d_ready=1, next cycle y0=8'h22, y_valid[0]=1.
REQ-031 Preload all four channels, assert rst with d_valid=1 -> next cycle y_valid=0, y0..y3=0, accept_cnt=0.
REQ-032 Drive 65537 beats with y_ready=4'hF -> accept_cnt wraps to 1.
REQ-033 DEMUX_RR_EN defined, 5 beats 8'h01..8'h05 with sel=0, y_ready=4'hF -> delivered on y0,y1,y2,y3,y0 in order.
